// File: rtl/shift_merge_stage.sv
// shift_merge_stage: two-stage shift/merge execution stage around an external
// combinational 32-bit double-shift-right unit (DSR, EXTR, DEP).
// Bit numbering in the op fields is big-endian (field position 0 = MSB).
// Optional: define SHIFT_MERGE_ILLEGAL_TRAP_EN to add out_trap and trap op 11.
module shift_merge_stage #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SA_W-1:0]  in_pos,
    input  logic [SA_W-1:0]  in_len,
    input  logic             in_sign,
    output logic [WIDTH-1:0] dsr_a,
    output logic [WIDTH-1:0] dsr_b,
    output logic [SA_W-1:0]  dsr_sa,
    input  logic [WIDTH-1:0] dsr_y,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
    output logic             out_trap,
`endif
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        OP_DSR  = 2'b00,
        OP_EXTR = 2'b01,
        OP_DEP  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SA_W-1:0]  pos;
        logic [SA_W-1:0]  len;
        logic             sign;
    } s1_t;

    localparam logic [SA_W-1:0] MAX_POS = SA_W'(WIDTH - 1);

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             s2_adv;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
    logic             out_trap_q, out_trap_d;
    logic             result_trap;
`endif

    // Handshake: S2 can take a new value when empty or being drained.
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept   = in_valid && in_ready;
    end

    // S1 next state: load on accept, empty out when it advances into S2.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.op    = op_e'(in_op);
            s1_d.a     = in_a;
            s1_d.b     = in_b;
            s1_d.pos   = in_pos;
            s1_d.len   = in_len;
            s1_d.sign  = in_sign;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Double-shift unit drive, derived from the S1 operand registers.
    always_comb begin
        dsr_a  = s1_q.a;
        dsr_b  = s1_q.b;
        dsr_sa = s1_q.pos;
        case (s1_q.op)
            OP_EXTR: begin
                // Shift the field's rightmost bit down to result LSB.
                dsr_a  = '0;
                dsr_b  = s1_q.a;
                dsr_sa = MAX_POS - s1_q.pos;
            end
            OP_DEP: begin
                // Rotate right so source LSB lands on field position pos.
                dsr_a  = s1_q.a;
                dsr_b  = s1_q.a;
                dsr_sa = s1_q.pos + SA_W'(1);
            end
            default: begin
                dsr_a  = s1_q.a;
                dsr_b  = s1_q.b;
                dsr_sa = s1_q.pos;
            end
        endcase
    end

    // Result formation: extract mask/sign-extend, deposit merge.
    always_comb begin
        logic [WIDTH-1:0] len_mask;
        logic [WIDTH-1:0] dep_mask;
        logic [WIDTH-1:0] extr_val;
        logic [SA_W-1:0]  sign_idx;

        // len == 0 encodes a full-width field.
        len_mask = (s1_q.len == '0) ? '1 : ((WIDTH'(1) << s1_q.len) - WIDTH'(1));
        // Field bit (32-L) big-endian is little-endian bit L-1; wraps to 31 for L=32.
        sign_idx = s1_q.len - SA_W'(1);
        extr_val = dsr_y & len_mask;
        if (s1_q.sign && dsr_y[sign_idx]) begin
            extr_val = extr_val | ~len_mask;
        end
        // Shifting the field mask up clips bits that would pass the MSB.
        dep_mask = len_mask << (MAX_POS - s1_q.pos);

`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
        result_trap = 1'b0;
`endif
        case (s1_q.op)
            OP_EXTR: result = extr_val;
            OP_DEP:  result = (dsr_y & dep_mask) | (s1_q.b & ~dep_mask);
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
            OP_RSV: begin
                result      = '0;
                result_trap = 1'b1;
            end
`endif
            default: result = dsr_y;
        endcase
    end

    // S2 next state: load from S1 when advancing, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
        out_trap_d  = out_trap_q;
`endif
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = result;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
                out_trap_d = result_trap;
`endif
            end
        end
    end

    // Pipeline registers; asynchronous reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
            out_trap_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
            out_trap_q  <= out_trap_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef SHIFT_MERGE_ILLEGAL_TRAP_EN
    assign out_trap  = out_trap_q;
`endif

endmodule
